clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
Single-clock divided-clock generator and tap scheduler for the tile's clock-divider/AND datapath. One free-running counter produces the div2/div4/div8/div16 levels, which replaces the ripple-clocked flops.
- A valid/ready command port selects one tap for a muxed output and sets an AND-combine mask.
- New commands take effect only at counter wrap, where every tap is low, so output switchover is glitch-free.
- Sits between the tile pin wrapper (ui_in/uio_in commands) and uo_out.

Parameters:
CNT_W, 4, counter width = number of taps (div2 .. div2^CNT_W); legal 2..8
SEL_W, 2, width of tap select; must be >= clog2(CNT_W)
MASK_RST, 4'b0101, AND mask after reset (div2 & div8); width CNT_W

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  count enable; 0 freezes counter
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_sel  in  SEL_W  tap select (0=div2, 1=div4, ...)
cmd_mask  in  CNT_W  AND-combine mask, bit i = tap i
div_taps  out  CNT_W  tap levels, div_taps[i] = cnt[i]
sel_out  out  1  div_taps[active_sel]
and_out  out  1  AND of div_taps over active_mask; 0 when active_mask==0
tick  out  1  wrap pulse
busy  out  1  command pending

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, active_sel=0, active_mask=MASK_RST, shadow regs=0, state=IDLE.
  - Outputs: div_taps=0, sel_out=0, and_out=0, tick=0, busy=0, cmd_ready=1.
- Counter:
  - cnt increments by 1 on each clk with ena=1, mod 2^CNT_W.
  - Held when ena=0.
  - div_taps[i] toggles every 2^i enabled cycles, so period = 2^(i+1) enabled cycles.
- wrap = ena & (cnt == all-ones).
- tick = wrap, combinational from registered state. One cycle wide, once per 2^CNT_W enabled cycles.
- FSM states IDLE, PEND:
  - IDLE: cmd_ready=1, busy=0. On cmd_valid & cmd_ready:
    - shadow_sel <= cmd_sel, clamped to CNT_W-1 if out of range.
    - shadow_mask <= cmd_mask.
    - Go to PEND.
  - PEND: cmd_ready=0, busy=1. cmd_valid is ignored. On wrap:
    - active_sel <= shadow_sel, active_mask <= shadow_mask.
    - Go to IDLE.
- Apply timing:
  - New config becomes visible in the same cycle cnt becomes 0.
  - All taps are 0 at that point, so sel_out and and_out are 0 under both the old and new config: no glitch.
- Latency: command accepted at counter value c is applied after (2^CNT_W - 1 - c) + 1 further enabled cycles, maximum 2^CNT_W.
- Command accepted in a cycle that is itself a wrap:
  - That wrap is NOT used.
  - The command applies at the next wrap, 2^CNT_W enabled cycles later.
- ena=0 while in PEND: remains pending indefinitely, and tick stays 0.
- Commands are accepted while ena=0.
- One command is outstanding at most; there is no queue.
- Re-sending an identical config is legal and goes through the same PEND cycle.
- Reset during PEND: pending command discarded; active_* returns to reset values.
- sel_out and and_out are combinational from registers only, with no input-to-output paths.

Test Plan:
- Reset, ena=1, 32 cycles, default config:
  - div_taps[0] toggles every cycle, div_taps[3] period 16.
  - tick high at cycles 15 and 31.
  - and_out = cnt[0] & cnt[2], high on cnt 5, 7, 13, 15.
  - cmd_ready=1 throughout.
- At cnt=3, send cmd_sel=3, cmd_mask=4'b0011:
  - cmd_ready=0 and busy=1 for cycles cnt 4..15.
  - Applied when cnt=0; sel_out follows cnt[3] from then on.
  - and_out high on cnt 3, 7, 11, 15.
  - cmd_ready=1 at cnt=0.
- Command accepted at cnt=15 (wrap cycle): not applied at that wrap; applied 16 cycles later; busy high for those 16 cycles.
- ena=0 for 20 cycles while PEND at cnt=9:
  - cnt holds 9, tick=0, busy stays 1.
  - After ena returns, applies after 7 enabled cycles.
- cmd_sel=3 with CNT_W=3 → clamped to 2; sel_out follows cnt[2].
- cmd_mask=0 → and_out constant 0.
- rst_n pulsed low mid-PEND (cnt=6, no clk edge needed):
  - All outputs return to reset values immediately.
  - active_sel=0, active_mask=MASK_RST.
  - Pending command lost; cmd_ready=1 after release.

Source files
------------

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - divided-clock tap generator with wrap-aligned glitch-free config switchover
module clk_div_sched #(
   parameter int                CNT_W    = 4,
   parameter int                SEL_W    = 2,
   parameter logic [CNT_W-1:0]  MASK_RST = 4'b0101
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [SEL_W-1:0]  cmd_sel,
   input  logic [CNT_W-1:0]  cmd_mask,
   output logic [CNT_W-1:0]  div_taps,
   output logic              sel_out,
   output logic              and_out,
   output logic              tick,
   output logic              busy
);

   localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(CNT_W - 1);

   typedef enum logic {IDLE, PEND} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [SEL_W-1:0]    active_sel;
   logic [CNT_W-1:0]    active_mask;
   logic [SEL_W-1:0]    shadow_sel;
   logic [CNT_W-1:0]    shadow_mask;
   logic                wrap;

   assign wrap = ena & (cnt == {CNT_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (ena) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The wrap seen while still IDLE is never used, so a command accepted on a
   // wrap cycle waits a full counter period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         active_sel  <= '0;
         active_mask <= MASK_RST;
         shadow_sel  <= '0;
         shadow_mask <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  shadow_sel  <= (cmd_sel > MAX_SEL) ? MAX_SEL : cmd_sel;
                  shadow_mask <= cmd_mask;
                  state       <= PEND;
               end
            end
            PEND: begin
               if (wrap) begin
                  active_sel  <= shadow_sel;
                  active_mask <= shadow_mask;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == PEND);
   assign tick      = wrap;
   assign div_taps  = cnt;
   assign sel_out   = cnt[active_sel];
   // Unmasked taps read as 1; an empty mask forces the output low.
   assign and_out   = (|active_mask) & (&(cnt | ~active_mask));

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - directed bench for clk_div_sched
module tb_clk_div_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_sel;
   logic [3:0] cmd_mask;
   logic [3:0] div_taps;
   logic       sel_out, and_out, tick, busy;

   logic       cmd_valid2;
   logic       cmd_ready2;
   logic [1:0] cmd_sel2;
   logic [2:0] cmd_mask2;
   logic [2:0] div_taps2;
   logic       sel_out2, and_out2, tick2, busy2;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   clk_div_sched #(.CNT_W(4), .SEL_W(2), .MASK_RST(4'b0101)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_mask(cmd_mask),
      .div_taps(div_taps), .sel_out(sel_out), .and_out(and_out), .tick(tick), .busy(busy)
   );

   clk_div_sched #(.CNT_W(3), .SEL_W(2), .MASK_RST(3'b101)) dut3 (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_sel(cmd_sel2), .cmd_mask(cmd_mask2),
      .div_taps(div_taps2), .sel_out(sel_out2), .and_out(and_out2), .tick(tick2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " taps"},  8'(div_taps), 8'h0);
      chk({tag, " sel"},   8'(sel_out),  8'h0);
      chk({tag, " and"},   8'(and_out),  8'h0);
      chk({tag, " tick"},  8'(tick),     8'h0);
      chk({tag, " busy"},  8'(busy),     8'h0);
      chk({tag, " ready"}, 8'(cmd_ready), 8'h1);
   endtask

   initial begin
      logic [3:0] k4;
      logic [2:0] k3;
      rst_n = 1'b0; ena = 1'b0;
      cmd_valid = 1'b0; cmd_sel = '0; cmd_mask = '0;
      cmd_valid2 = 1'b0; cmd_sel2 = '0; cmd_mask2 = '0;

      #12;
      chk_reset_outputs("rst");
      step();
      rst_n = 1'b1; ena = 1'b1;

      // default config: sel=div2, and = div2 & div8
      for (int i = 0; i < 32; i++) begin
         k4 = 4'(i);
         chk("t1 taps",  8'(div_taps), 8'(k4));
         chk("t1 tick",  8'(tick),  8'(k4 == 4'd15));
         chk("t1 and",   8'(and_out), 8'(k4 == 5 || k4 == 7 || k4 == 13 || k4 == 15));
         chk("t1 sel",   8'(sel_out), 8'(k4[0]));
         chk("t1 ready", 8'(cmd_ready), 8'h1);
         step();
      end

      // command at cnt=3
      step(); step(); step();
      chk("t2 cnt3", 8'(div_taps), 8'd3);
      cmd_valid = 1'b1; cmd_sel = 2'd3; cmd_mask = 4'b0011;
      step();
      cmd_valid = 1'b0;
      for (int k = 4; k < 16; k++) begin
         k4 = 4'(k);
         chk("t2 busy",  8'(busy), 8'h1);
         chk("t2 ready", 8'(cmd_ready), 8'h0);
         chk("t2 oldsel", 8'(sel_out), 8'(k4[0]));
         step();
      end
      chk("t2 ready@0", 8'(cmd_ready), 8'h1);
      chk("t2 busy@0",  8'(busy), 8'h0);
      for (int k = 0; k < 16; k++) begin
         k4 = 4'(k);
         chk("t2 sel", 8'(sel_out), 8'(k4[3]));
         chk("t2 and", 8'(and_out), 8'(k4 == 3 || k4 == 7 || k4 == 11 || k4 == 15));
         step();
      end

      // command accepted on a wrap cycle
      for (int i = 0; i < 15; i++) step();
      chk("t3 tick", 8'(tick), 8'h1);
      cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_mask = 4'b0101;
      step();
      cmd_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         k4 = 4'(k);
         chk("t3 busy", 8'(busy), 8'h1);
         chk("t3 oldsel", 8'(sel_out), 8'(k4[3]));
         step();
      end
      chk("t3 busy@0", 8'(busy), 8'h0);
      step();
      chk("t3 newsel@1", 8'(sel_out), 8'h1);

      // pending through an ena=0 stall at cnt=9
      cmd_valid = 1'b1; cmd_sel = 2'd2; cmd_mask = 4'b0000;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("t4 cnt9", 8'(div_taps), 8'd9);
      chk("t4 busy", 8'(busy), 8'h1);
      ena = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("t4 hold", 8'(div_taps), 8'd9);
         chk("t4 tick", 8'(tick), 8'h0);
         chk("t4 busy", 8'(busy), 8'h1);
      end
      ena = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("t4 busy@15", 8'(busy), 8'h1);
      chk("t4 tick@15", 8'(tick), 8'h1);
      step();
      chk("t4 applied", 8'(busy), 8'h0);
      for (int k = 0; k < 16; k++) begin
         k4 = 4'(k);
         chk("t4 and0", 8'(and_out), 8'h0);
         chk("t4 sel2", 8'(sel_out), 8'(k4[2]));
         step();
      end

      // reset mid-PEND at cnt=6
      cmd_valid = 1'b1; cmd_sel = 2'd3; cmd_mask = 4'b1111;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("t6 cnt6", 8'(div_taps), 8'd6);
      chk("t6 busy", 8'(busy), 8'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6 async");
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         k4 = 4'(k);
         k3 = 3'(k);
         chk("t6 and",   8'(and_out), 8'(k4 == 5 || k4 == 7 || k4 == 13 || k4 == 15));
         chk("t6 sel",   8'(sel_out), 8'(k4[0]));
         chk("t6 ready", 8'(cmd_ready), 8'h1);
         chk("t6 taps3", 8'(div_taps2), 8'(k3));
         chk("t6 and3",  8'(and_out2), 8'(k3 == 5 || k3 == 7));
         step();
      end

      // out-of-range select on the 3-tap instance
      cmd_valid2 = 1'b1; cmd_sel2 = 2'd3; cmd_mask2 = 3'b000;
      step();
      cmd_valid2 = 1'b0;
      chk("t5 busy", 8'(busy2), 8'h1);
      for (int i = 0; i < 7; i++) step();
      chk("t5 applied", 8'(busy2), 8'h0);
      for (int k = 0; k < 8; k++) begin
         k3 = 3'(k);
         chk("t5 clamp", 8'(sel_out2), 8'(k3[2]));
         chk("t5 and0",  8'(and_out2), 8'h0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
